// File: rtl/decode_pkg.sv
// Shared types for the LoongArch 2RI12 ALU decode queue: opcodes, ALU encodings
// and the micro-op record that is stored in the queue.
package decode_pkg;

  typedef enum logic [9:0] {
    OP_SLTI  = 10'h008,
    OP_SLTUI = 10'h009,
    OP_ADDIW = 10'h00A,
    OP_ANDI  = 10'h00D,
    OP_ORI   = 10'h00E,
    OP_XORI  = 10'h00F
  } opcode_e;

  typedef enum logic [7:0] {
    ALU_NOP   = 8'h00,
    ALU_SLTI  = 8'h01,
    ALU_SLTUI = 8'h02,
    ALU_ADDIW = 8'h03,
    ALU_ANDI  = 8'h04,
    ALU_ORI   = 8'h05,
    ALU_XORI  = 8'h06
  } aluop_e;

  typedef enum logic [2:0] {
    NOP        = 3'd0,
    ARITHMETIC = 3'd1
  } alusel_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    aluop_e      aluop;
    alusel_e     alusel;
    logic [31:0] imm;
    logic [4:0]  rj;
    logic [4:0]  rd;
    logic        reg_we;
    logic        inst_valid;
  } uop_t;

  function automatic logic [31:0] signExt12(input logic [11:0] field);
    return {{20{field[11]}}, field};
  endfunction

  function automatic logic [31:0] zeroExt12(input logic [11:0] field);
    return {20'd0, field};
  endfunction

endpackage

// File: rtl/decoder_2ri12_lane.sv
// Combinational decode of a single 2RI12-format instruction into a micro-op.
module decoder_2ri12_lane
  import decode_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [31:0] inst_i,
  output uop_t        uop_o
);

  logic        known;
  aluop_e      aluop;
  logic [31:0] imm;

  always_comb begin
    known = 1'b1;
    aluop = ALU_NOP;
    imm   = '0;
    case (inst_i[31:22])
      OP_SLTI:  begin aluop = ALU_SLTI;  imm = signExt12(inst_i[21:10]); end
      OP_SLTUI: begin aluop = ALU_SLTUI; imm = signExt12(inst_i[21:10]); end
      OP_ADDIW: begin aluop = ALU_ADDIW; imm = signExt12(inst_i[21:10]); end
      OP_ANDI:  begin aluop = ALU_ANDI;  imm = zeroExt12(inst_i[21:10]); end
      OP_ORI:   begin aluop = ALU_ORI;   imm = zeroExt12(inst_i[21:10]); end
      OP_XORI:  begin aluop = ALU_XORI;  imm = zeroExt12(inst_i[21:10]); end
      default:  known = 1'b0;
    endcase
  end

  // Unknown opcodes still produce a micro-op so dispatch can raise INE in order.
  always_comb begin
    uop_o.pc         = pc_i;
    uop_o.inst       = inst_i;
    uop_o.aluop      = aluop;
    uop_o.alusel     = known ? ARITHMETIC : NOP;
    uop_o.imm        = imm;
    uop_o.rj         = inst_i[9:5];
    uop_o.rd         = inst_i[4:0];
    uop_o.reg_we     = known;
    uop_o.inst_valid = known;
  end

endmodule

// File: rtl/decode_queue_2ri12.sv
// Multi-lane 2RI12 decode stage: parallel lane decode, compaction of valid lanes
// into a circular micro-op queue, and in-order multi-lane issue to dispatch.
module decode_queue_2ri12
  import decode_pkg::*;
#(
  parameter int FETCH_WIDTH = 2,
  parameter int ISSUE_WIDTH = 2,
  parameter int DEPTH       = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic [FETCH_WIDTH-1:0]   in_valid,
  input  logic [32*FETCH_WIDTH-1:0] in_pc,
  input  logic [32*FETCH_WIDTH-1:0] in_inst,
  output logic                     in_ready,
  output logic [ISSUE_WIDTH-1:0]   out_valid,
  input  logic                     out_ready,
  output logic [32*ISSUE_WIDTH-1:0] out_pc,
  output logic [32*ISSUE_WIDTH-1:0] out_inst,
  output logic [8*ISSUE_WIDTH-1:0]  out_aluop,
  output logic [3*ISSUE_WIDTH-1:0]  out_alusel,
  output logic [32*ISSUE_WIDTH-1:0] out_imm,
  output logic [5*ISSUE_WIDTH-1:0]  out_rj,
  output logic [5*ISSUE_WIDTH-1:0]  out_rd,
  output logic [ISSUE_WIDTH-1:0]   out_reg_we,
  output logic [ISSUE_WIDTH-1:0]   out_inst_valid
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] FW_C    = CW'(FETCH_WIDTH);
  localparam logic [CW-1:0] IW_C    = CW'(ISSUE_WIDTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  uop_t          mem_q   [DEPTH];
  uop_t          laneUop [FETCH_WIDTH];
  logic [CW-1:0] laneOff [FETCH_WIDTH];

  logic          doPush;
  logic [CW-1:0] pushCnt;
  logic [CW-1:0] pushAmt;
  logic [CW-1:0] avail;
  logic [CW-1:0] popAmt;

  for (genvar i = 0; i < FETCH_WIDTH; i++) begin : g_lane
    decoder_2ri12_lane u_dec (
      .pc_i   (in_pc[32*i +: 32]),
      .inst_i (in_inst[32*i +: 32]),
      .uop_o  (laneUop[i])
    );
  end

  // Admission looks only at registered occupancy, never at a same-cycle pop.
  assign in_ready = (DEPTH_C - count_q) >= FW_C;
  assign doPush   = in_ready && !flush;

  // Each valid lane lands at wr_ptr plus the number of valid lanes below it.
  always_comb begin
    pushCnt = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      laneOff[i] = pushCnt;
      pushCnt    = pushCnt + CW'(in_valid[i]);
    end
    pushAmt = doPush ? pushCnt : '0;
    avail   = (count_q > IW_C) ? IW_C : count_q;
    popAmt  = out_ready ? avail : '0;

    wr_ptr_d = wr_ptr_q + pushAmt[PW-1:0];
    rd_ptr_d = rd_ptr_q + popAmt[PW-1:0];
    count_d  = count_q + pushAmt - popAmt;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset: entries outside [rd_ptr, rd_ptr+count) are never observed.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (doPush && in_valid[i]) begin
        mem_q[wr_ptr_q + laneOff[i][PW-1:0]] <= laneUop[i];
      end
    end
  end

  for (genvar k = 0; k < ISSUE_WIDTH; k++) begin : g_issue
    uop_t headUop;
    assign headUop = mem_q[rd_ptr_q + PW'(k)];

    assign out_valid[k]          = count_q > CW'(k);
    assign out_pc[32*k +: 32]    = headUop.pc;
    assign out_inst[32*k +: 32]  = headUop.inst;
    assign out_aluop[8*k +: 8]   = headUop.aluop;
    assign out_alusel[3*k +: 3]  = headUop.alusel;
    assign out_imm[32*k +: 32]   = headUop.imm;
    assign out_rj[5*k +: 5]      = headUop.rj;
    assign out_rd[5*k +: 5]      = headUop.rd;
    assign out_reg_we[k]         = headUop.reg_we;
    assign out_inst_valid[k]     = headUop.inst_valid;
  end

endmodule

// File: tb/tb_decode_queue_2ri12.sv
// Scoreboard bench for decode_queue_2ri12: a driver queues expected micro-ops
// from a spec-level decode model, a monitor checks and retires them.
module tb_decode_queue_2ri12;
  import decode_pkg::*;

  localparam int FW    = 2;
  localparam int IW    = 2;
  localparam int DEPTH = 8;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] imm;
    logic [4:0]  rj;
    logic [4:0]  rd;
    logic        we;
    logic        iv;
  } expT;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic [FW-1:0]     in_valid;
  logic [32*FW-1:0]  in_pc;
  logic [32*FW-1:0]  in_inst;
  logic              in_ready;
  logic [IW-1:0]     out_valid;
  logic              out_ready;
  logic [32*IW-1:0]  out_pc;
  logic [32*IW-1:0]  out_inst;
  logic [8*IW-1:0]   out_aluop;
  logic [3*IW-1:0]   out_alusel;
  logic [32*IW-1:0]  out_imm;
  logic [5*IW-1:0]   out_rj;
  logic [5*IW-1:0]   out_rd;
  logic [IW-1:0]     out_reg_we;
  logic [IW-1:0]     out_inst_valid;

  int compared   = 0;
  int mismatched = 0;

  expT mainQ[$];
  expT pendQ[$];

  decode_queue_2ri12 #(.FETCH_WIDTH(FW), .ISSUE_WIDTH(IW), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_pc          (in_pc),
    .in_inst        (in_inst),
    .in_ready       (in_ready),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .out_aluop      (out_aluop),
    .out_alusel     (out_alusel),
    .out_imm        (out_imm),
    .out_rj         (out_rj),
    .out_rd         (out_rd),
    .out_reg_we     (out_reg_we),
    .out_inst_valid (out_inst_valid)
  );

  always #5 clk = ~clk;

  function automatic expT expDecode(input logic [31:0] pc, input logic [31:0] inst);
    expT e;
    logic [11:0] f;
    f = inst[21:10];
    e.pc = pc;
    e.inst = inst;
    e.rj = inst[9:5];
    e.rd = inst[4:0];
    e.we = 1'b1;
    e.iv = 1'b1;
    e.alusel = 3'd1;
    case (inst[31:22])
      10'h008: begin e.aluop = ALU_SLTI;  e.imm = {{20{f[11]}}, f}; end
      10'h009: begin e.aluop = ALU_SLTUI; e.imm = {{20{f[11]}}, f}; end
      10'h00A: begin e.aluop = ALU_ADDIW; e.imm = {{20{f[11]}}, f}; end
      10'h00D: begin e.aluop = ALU_ANDI;  e.imm = {20'd0, f}; end
      10'h00E: begin e.aluop = ALU_ORI;   e.imm = {20'd0, f}; end
      10'h00F: begin e.aluop = ALU_XORI;  e.imm = {20'd0, f}; end
      default: begin
        e.aluop = 8'h00; e.imm = 32'd0; e.alusel = 3'd0; e.we = 1'b0; e.iv = 1'b0;
      end
    endcase
    return e;
  endfunction

  function automatic logic [118:0] packExp(input expT e);
    return {e.pc, e.inst, e.aluop, e.alusel, e.imm, e.rj, e.rd, e.we, e.iv};
  endfunction

  function automatic logic [31:0] randInst();
    logic [9:0] opc;
    int sel;
    sel = $urandom_range(0, 7);
    case (sel)
      0: opc = 10'h008;
      1: opc = 10'h009;
      2: opc = 10'h00A;
      3: opc = 10'h00D;
      4: opc = 10'h00E;
      5: opc = 10'h00F;
      default: opc = 10'($urandom);
    endcase
    return {opc, 22'($urandom)};
  endfunction

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; accepted lanes are queued as pending
  // and become visible to the monitor model at the following rising edge.
  task automatic applyStimulus(input logic [FW-1:0] v, input logic [32*FW-1:0] pcs,
                               input logic [32*FW-1:0] insts, input logic ordy, input logic fl);
    @(negedge clk);
    in_valid  = v;
    in_pc     = pcs;
    in_inst   = insts;
    out_ready = ordy;
    flush     = fl;
    if (rst_n && !fl && (DEPTH - mainQ.size()) >= FW) begin
      for (int i = 0; i < FW; i++) begin
        if (v[i]) pendQ.push_back(expDecode(pcs[32*i +: 32], insts[32*i +: 32]));
      end
    end
  endtask

  task automatic randomCycles(input int n, input int flushPct, input int readyPct);
    for (int c = 0; c < n; c++) begin
      applyStimulus(FW'($urandom), {$urandom, $urandom}, {randInst(), randInst()},
                    $urandom_range(0, 99) < readyPct, $urandom_range(0, 99) < flushPct);
    end
  endtask

  task automatic drainQueue(input int n);
    repeat (n) applyStimulus('0, '0, '0, 1'b1, 1'b0);
  endtask

  task automatic doAsyncReset();
    @(negedge clk);
    #2;
    rst_n     = 1'b0;
    in_valid  = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
    mainQ.delete();
    pendQ.delete();
    #1;
    checkOutput("async_rst_out_valid", 256'(out_valid), 256'(0));
    checkOutput("async_rst_in_ready", 256'(in_ready), 256'(1));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: compare the DUT's presented lanes against the model head, then retire.
  initial begin
    int n;
    logic [IW-1:0] expOv;
    logic [118:0] actVec;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n === 1'b1) begin
        n = mainQ.size();
        checkOutput("in_ready", 256'(in_ready), 256'((DEPTH - n) >= FW));
        for (int k = 0; k < IW; k++) expOv[k] = (n > k);
        checkOutput("out_valid", 256'(out_valid), 256'(expOv));
        for (int k = 0; k < IW; k++) begin
          if (k < n) begin
            actVec = {out_pc[32*k +: 32], out_inst[32*k +: 32], out_aluop[8*k +: 8],
                      out_alusel[3*k +: 3], out_imm[32*k +: 32], out_rj[5*k +: 5],
                      out_rd[5*k +: 5], out_reg_we[k], out_inst_valid[k]};
            checkOutput($sformatf("lane%0d_uop", k), 256'(actVec), 256'(packExp(mainQ[k])));
          end
        end
        if (flush) begin
          mainQ.delete();
          pendQ.delete();
        end else begin
          if (out_ready) begin
            for (int k = 0; k < IW && mainQ.size() > 0; k++) void'(mainQ.pop_front());
          end
          while (pendQ.size() > 0) mainQ.push_back(pendQ.pop_front());
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = '0;
    in_pc     = '0;
    in_inst   = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset_out_valid", 256'(out_valid), 256'(0));
    checkOutput("reset_in_ready", 256'(in_ready), 256'(1));
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(2'b01, {32'h0, 32'h0000_1000}, {32'h0, 32'h0280_0421}, 1'b0, 1'b0);
    applyStimulus(2'b11, {32'h0000_1008, 32'h0000_1004}, {32'h023F_FC83, 32'h03BF_FC02}, 1'b1, 1'b0);
    applyStimulus(2'b10, {32'h0000_2004, 32'h0000_2000}, {32'hFFC0_0123, 32'h0280_0421}, 1'b1, 1'b0);
    drainQueue(4);

    applyStimulus(2'b01, {$urandom, $urandom}, {randInst(), randInst()}, 1'b0, 1'b0);
    repeat (5) applyStimulus(2'b11, {$urandom, $urandom}, {randInst(), randInst()}, 1'b0, 1'b0);
    randomCycles(40, 0, 100);

    repeat (2) applyStimulus(2'b11, {$urandom, $urandom}, {randInst(), randInst()}, 1'b0, 1'b0);
    applyStimulus(2'b11, {$urandom, $urandom}, {randInst(), randInst()}, 1'b1, 1'b1);
    applyStimulus(2'b00, '0, '0, 1'b0, 1'b0);

    randomCycles(300, 5, 70);
    drainQueue(6);

    repeat (3) applyStimulus(2'b11, {$urandom, $urandom}, {randInst(), randInst()}, 1'b0, 1'b0);
    doAsyncReset();

    randomCycles(100, 3, 60);
    drainQueue(6);
    @(negedge clk);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/decode_queue_2ri12.md
# decode_queue_2ri12

Parametrised multi-lane decode stage for LoongArch 2RI12-format ALU instructions. It accepts up to FETCH_WIDTH instructions per cycle from the fetch buffer and decodes each lane in parallel. Decoded micro-ops are compacted into a DEPTH-entry circular queue, and up to ISSUE_WIDTH of them are presented per cycle to dispatch under a valid/ready handshake. It sits between instruction fetch and dispatch/issue, and adds XORI, lane compaction, buffering and flush to single-instruction combinational decode.

## Interface
- FETCH_WIDTH, 2, input lanes per cycle (1..4)
- ISSUE_WIDTH, 2, output lanes per cycle (1..4)
- DEPTH, 8, queue entries; power of two, ≥ max(FETCH_WIDTH, ISSUE_WIDTH)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset; asynchronous and active-low
- flush  in  1  discard all queued entries and this cycle's input
- in_valid  in  FETCH_WIDTH  per-lane valid; may be sparse, e.g. 2'b10
- in_pc  in  32*FETCH_WIDTH  lane i at [32i+31:32i]
- in_inst  in  32*FETCH_WIDTH  raw instruction words
- in_ready  out  1  queue has ≥ FETCH_WIDTH free entries
- out_valid  out  ISSUE_WIDTH  thermometer code, lane 0 is oldest
- out_ready  in  1  dispatch takes every valid output lane this cycle
- out_pc, out_inst  out  32*ISSUE_WIDTH  pass-through of the input pc and instruction word
- out_aluop  out  8*ISSUE_WIDTH  ALU operation
- out_alusel  out  3*ISSUE_WIDTH  ALU select
- out_imm  out  32*ISSUE_WIDTH  extended immediate
- out_rj, out_rd  out  5*ISSUE_WIDTH  source register (inst[9:5]) / destination register (inst[4:0])
- out_reg_we  out  ISSUE_WIDTH  destination-register write enable
- out_inst_valid  out  ISSUE_WIDTH  0 = unrecognised opcode; dispatch raises INE

## Operation
- **Per-lane decode** (combinational, on opcode inst[31:22]):
  - SLTI 0x008, SLTUI 0x009, ADDI.W 0x00A: imm = sign-extended inst[21:10].
  - ANDI 0x00D, ORI 0x00E, XORI 0x00F: imm = zero-extended inst[21:10].
  - Recognised opcode: reg_we=1, alusel=ARITHMETIC, inst_valid=1, aluop set per opcode (ANDI → ALU_ANDI).
  - Any other opcode: aluop=ALU_NOP, alusel=NOP, reg_we=0, imm=0, inst_valid=0.
  - Unrecognised instructions are still enqueued; they are never dropped.
- **Enqueue:** when in_ready && !flush, the valid lanes are written in ascending lane order to consecutive slots starting at wr_ptr. wr_ptr advances by popcount(in_valid). Invalid lanes consume no slot.
- **Dequeue:** out_valid[k] = (count > k). When out_ready is high, rd_ptr advances by popcount(out_valid).
- **Pointers:** both wrap modulo DEPTH. count is $clog2(DEPTH)+1 bits wide, and count_next = count + pushed − popped.
- **Simultaneous push and pop** in one cycle is allowed.
- in_ready is computed from the current count only: DEPTH − count ≥ FETCH_WIDTH. Space freed by a same-cycle pop is not counted.
- **Flush** has priority over push and pop. Next edge: wr_ptr = rd_ptr = count = 0, and all pending input and output transfers are cancelled.
- **Reset:** pointers and count go to 0, so out_valid=0 and in_ready=1. Output data fields read queue storage; their values are don't-care while out_valid=0. Reset asserted mid-transfer discards all entries.

## Timing
- Latency: an instruction accepted at edge N is visible on out_valid from cycle N+1 (one cycle). There is no combinational path from in_* to out_*.
- in_ready depends only on registered state; it has no combinational dependence on out_ready.
- Output lane data stays stable while out_valid is held and out_ready is low.
- Throughput: min(FETCH_WIDTH, ISSUE_WIDTH) instructions per cycle in steady state.

## Structure
- **Package `decode_pkg`** holds:
  - opcode constants (SLTI … XORI);
  - aluop encodings: ALU_NOP=8'h00, ALU_SLTI, ALU_SLTUI, ALU_ADDIW, ALU_ANDI, ALU_ORI, ALU_XORI;
  - alusel encodings: NOP=3'd0, ARITHMETIC=3'd1;
  - typedef `uop_t`, packing pc, inst, aluop, alusel, imm, rj, rd, reg_we, inst_valid.
- **Sub-module `decoder_2ri12_lane`:** a purely combinational decode of one lane, instantiated FETCH_WIDTH times via generate. The queue storage is an array of uop_t.

## Test plan
- Reset, then in_valid=2'b01 with in_inst 0x02800421 (addi.w r1,r1,1) → next cycle out_valid=2'b01, aluop=ALU_ADDIW, imm=0x00000001, rj=1, rd=1, reg_we=1.
- Both lanes valid: 0x03BFFC02 (ori r2,r0,0xfff) and 0x023FFC83 (slti r3,r4,−1) → lane0 imm=0x00000FFF; lane1 imm=0xFFFFFFFF, rj=4, rd=3.
- Sparse input in_valid=2'b10 → a single entry, appearing on output lane 0 with lane-1 pc. Opcode 0x3FF → inst_valid=0, reg_we=0, aluop=ALU_NOP.
- Hold out_ready=0 and push 2 per cycle → in_ready drops when count=7 (DEPTH=8). Then out_ready=1 and continuous push across pointer wrap → in-order output, no loss or duplication.
- flush asserted together with a push and out_ready → next cycle count=0, out_valid=0, in_ready=1; the flushed input is never seen.
- rst_n pulsed low asynchronously with the queue half full → out_valid=0 immediately, without waiting for a clock edge.
